// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode enum and channel-count limit
package arb_pkg;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  localparam int ARB_MAX_N = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder, first set req at or after start wins
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 5,
  localparam int IDX_W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  logic [N-1:0] rot;
  logic [IDX_W:0] off, sum;
  always_comb begin
    rot = N'({req, req} >> start);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? (IDX_W+1)'(i) : off;
    sum = {1'b0, start} + off;
    gnt_idx = IDX_W'(sum >= (IDX_W+1)'(N) ? sum - (IDX_W+1)'(N) : sum);
    any = |req;
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-way arbitrated mux with valid/ready handshakes and a registered output stage
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 5,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int IDX_W = N > 1 ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  input  logic               out_ready
);
  logic [IDX_W-1:0] ptr, g;
  logic any, load;
  rr_pick #(.N(N)) u_pick (
    .req(in_valid),
    .start(MODE == ARB_RR ? ptr : '0),
    .gnt_idx(g),
    .any(any)
  );
  always_comb begin
    load = ~out_valid | out_ready;
    in_ready = (load & any & ~rst) ? N'(1) << g : '0;
  end
  // wrap is explicit so non-power-of-two N never points past the last channel
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= in_data[g*WIDTH +: WIDTH];
        out_idx <= g;
        ptr <= MODE == ARB_RR ? (g == IDX_W'(N - 1) ? '0 : g + IDX_W'(1)) : '0;
      end
    end
  end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-way arbitrated multiplexer with valid/ready handshakes and a one-entry registered output stage. It merges request streams, such as fetch, LSU, page-table walker, debug and DMA, onto a single shared port ahead of the memory/bus interface. It replaces fixed-select combinational muxes wherever the selection must be arbitrated rather than decoded, and wherever the output must be registered.

## Interface
Parameters:
- WIDTH, 32, payload width per channel.
- N, 5, number of input channels; legal range 1..16. Non-power-of-two values are legal.
- MODE, ARB_RR, arbitration mode: ARB_RR (round-robin) or ARB_FIXED (lowest index wins).
- IDX_W, derived localparam = max(1, $clog2(N)); not overridable.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel request valid.
- in_data  in  N*WIDTH  packed payloads; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept; at most one bit high in any cycle.
- out_valid  out  1  registered output valid.
- out_data  out  WIDTH  registered payload of the granted channel.
- out_idx  out  IDX_W  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

## Operation
- load = ~out_valid | out_ready. The output stage can take a new beat whenever load is high.
- Arbitration is evaluated every cycle over in_valid:
  - ARB_RR: search starts at ptr and proceeds ptr, ptr+1, …, N-1, 0, …, ptr-1. The first valid channel wins.
  - ARB_FIXED: the lowest valid index wins, and ptr is unused (held at 0).
- in_ready[g] = load & in_valid[g] & ~rst for the winner g. All other in_ready bits are 0.
- Transfer on input i occurs when in_valid[i] & in_ready[i].
- On a transfer at the clock edge:
  - out_data <= in_data[g], out_idx <= g, out_valid <= 1.
  - In ARB_RR mode, ptr <= (g == N-1) ? 0 : g+1. The wrap is explicit; do not rely on modulo-2^IDX_W.
- If load is high and no in_valid is set: out_valid <= 0; out_data and out_idx hold their values; ptr holds.
- If load is low: all registers hold. out_data and out_idx must stay stable while out_valid & ~out_ready.
- A new request arriving while the output is stalled does not change ptr or the output registers.
- Inputs are not required to hold in_valid while not granted. The block does not check that they do and stores nothing for them.
- N=1: the single channel always wins, out_idx is constantly 0, and ptr stays 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, ptr=0. While rst is high, in_ready is 0 regardless of other inputs.
- Latency: an input accepted at edge k is visible on out_* in the cycle after edge k (1 cycle).
- Throughput: one beat per cycle while out_ready stays high and any input is valid. There are no bubbles between back-to-back grants.
- Combinational paths: in_valid → in_ready, and out_ready → in_ready (load passes through). There is no combinational path from any input to out_*.
- Simultaneous out_ready and a new grant in the same cycle: the old beat drains and the new beat loads at the same edge. out_valid stays 1.
- Reset asserted mid-stream: any held beat is discarded (out_valid=0 at the next edge) and ptr returns to 0. No transfer is reported in the reset cycle.
- Fairness in ARB_RR: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive grants.

## Structure
- Shared package arb_pkg holds:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR}.
  - localparam ARB_MAX_N = 16.
- One sub-module, rr_pick. It is a combinational rotating-priority encoder:
  - Inputs: req[N] and start[IDX_W].
  - Outputs: gnt_idx[IDX_W] and any.
  - Implementation: double-width request vector rotated by start, then a lowest-set-bit search.
  - ARB_FIXED instantiates it with start tied to 0.
- rr_arb_mux holds ptr, the output register, and the load/in_ready logic.

## Test plan
- Reset: drive rst=1 for 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0 and out_idx=0 throughout. The first grant after release is channel 0.
- Round-robin fairness, N=5: all valid and out_ready=1 for 10 cycles. Required: out_idx sequence 0,1,2,3,4,0,1,2,3,4, with out_data equal to the per-channel tags 0xA0..0xA4.
- Backpressure: a beat from channel 2 is loaded, then out_ready=0 for 3 cycles while channels 0 and 3 are valid. Required:
  - out_data and out_idx hold 2 throughout.
  - in_ready=0 throughout.
  - When out_ready rises, channel 3 is granted in the same cycle (ptr=3).
- Wrap with sparse requests: ptr=4 and only channel 4 valid, then channels 1 and 4 valid. Required: grant 4, then grant 1 (ptr wraps 4→0 and the search skips 0).
- Fixed mode: MODE=ARB_FIXED with channels 1 and 3 both valid for 4 cycles. Required: channel 1 is granted every cycle and channel 3 is never granted.
- Idle bubble and mid-stream reset:
  - Drop all in_valid with out_ready=1. Required: out_valid falls the next cycle while out_data holds.
  - Then assert rst while out_valid=1 and out_ready=0. Required: out_valid=0 and ptr=0 after the edge.
